// File: rtl/code_decoder_3to8_pkg.sv
// Shared types and decode helpers for the 3-to-8 one-hot decoder.
// Optional thermometer mask output is enabled with DECODE_THERMO_EN.
package code_dec_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 1 << CODE_W;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} dec_state_e;

    function automatic logic [OUT_W-1:0] onehot_f(input logic [CODE_W-1:0] code);
        onehot_f       = '0;
        onehot_f[code] = 1'b1;
    endfunction

    // Bits [code:0] set, so code 0 still yields a non-empty mask.
    function automatic logic [OUT_W-1:0] thermo_f(input logic [CODE_W-1:0] code);
        for (int i = 0; i < OUT_W; i++) begin
            thermo_f[i] = (i <= int'(code));
        end
    endfunction

endpackage

// File: rtl/code_decoder_3to8_if.sv
// Valid/ready bus between the code producer, the decoder and the lane fan-out.
// out_mask exists only when DECODE_THERMO_EN is defined.
interface code_decoder_3to8_if #(
    parameter int CNT_W = 16
);
    import code_dec_pkg::*;

    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_onehot;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  xfer_count;
`ifdef DECODE_THERMO_EN
    logic [OUT_W-1:0]  out_mask;
`endif

    modport slave (
        input  in_code, in_valid, out_ready,
        output in_ready, out_onehot, out_valid, xfer_count
`ifdef DECODE_THERMO_EN
        , output out_mask
`endif
    );

    modport master (
        output in_code, in_valid, out_ready,
        input  in_ready, out_onehot, out_valid, xfer_count
`ifdef DECODE_THERMO_EN
        , input out_mask
`endif
    );

endinterface

// File: rtl/code_decoder_3to8_skid.sv
// Generic 2-entry valid/ready skid register; in_ready depends on state only.
// Both entries clear on reset so no stale word survives an abort.
module dec_skid_buf
    import code_dec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              xfer
);

    dec_state_e        state_p1, state_n;
    logic              in_ready_p1;
    logic [DATA_W-1:0] out_data_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              accept;
    logic              load_out, load_skid, move_skid;

    assign in_ready  = in_ready_p1;
    assign out_valid = (state_p1 != EMPTY);
    assign out_data  = out_data_p1;
    assign accept    = in_valid & in_ready_p1;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_n   = state_p1;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_p1)
            EMPTY: begin
                if (accept) begin
                    load_out = 1'b1;
                    state_n  = ONE;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_n   = TWO;
                end else if (xfer) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    move_skid = 1'b1;
                    state_n   = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // p1: state, ready flag and both data entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1     <= EMPTY;
            in_ready_p1  <= 1'b0;
            out_data_p1  <= '0;
            skid_data_p1 <= '0;
        end else begin
            state_p1    <= state_n;
            in_ready_p1 <= (state_n != TWO);
            if (load_out) begin
                out_data_p1 <= in_data;
            end else if (move_skid) begin
                out_data_p1 <= skid_data_p1;
            end
            if (load_skid) begin
                skid_data_p1 <= in_data;
            end
        end
    end

endmodule

// File: rtl/code_decoder_3to8.sv
// Registered 3-to-8 one-hot decoder behind a 2-entry skid stage, with a saturating
// output-handshake counter. DECODE_THERMO_EN adds the thermometer mask out_mask.
module code_decoder_3to8
    import code_dec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    code_decoder_3to8_if.slave   bus
);

`ifdef DECODE_THERMO_EN
    localparam int WORD_W = 2 * OUT_W;
`else
    localparam int WORD_W = OUT_W;
`endif

    logic [WORD_W-1:0] word_p0;
    logic [WORD_W-1:0] word_p1;
    logic              xfer;
    logic [CNT_W-1:0]  cnt_p1;

`ifdef DECODE_THERMO_EN
    assign word_p0       = {thermo_f(bus.in_code), onehot_f(bus.in_code)};
    assign bus.out_mask  = word_p1[WORD_W-1:OUT_W];
`else
    assign word_p0       = onehot_f(bus.in_code);
`endif
    assign bus.out_onehot = word_p1[OUT_W-1:0];
    assign bus.xfer_count = cnt_p1;

    dec_skid_buf #(
        .DATA_W (WORD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (word_p0),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (word_p1),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .xfer      (xfer)
    );

    // p1: handshake counter, sticks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (xfer && (cnt_p1 != '1)) begin
            cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_code_decoder_3to8.sv
// Bench for code_decoder_3to8: directed vector table plus random traffic against a queue model.
// Two instances share stimulus; the second has a 4-bit counter to exercise saturation.
module tb_code_decoder_3to8;
    import code_dec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    code_decoder_3to8_if #(.CNT_W(16)) bus ();
    code_decoder_3to8_if #(.CNT_W(4))  bus_s ();

    code_decoder_3to8 #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
    code_decoder_3to8 #(.CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

    typedef struct {
        bit       vld;
        bit [2:0] code;
        bit       ordy;
        bit       exp_rdy;
        bit       exp_vld;
        bit [7:0] exp_oh;
        int       exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: FIFO of accepted codes with room for two words.
    int q[$];
    int cnt;
    bit m_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit [2:0] c, input bit r);
        bus.in_valid    = v;
        bus.in_code     = c;
        bus.out_ready   = r;
        bus_s.in_valid  = v;
        bus_s.in_code   = c;
        bus_s.out_ready = r;
    endtask

    task automatic check_model();
        chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("out_valid_s", 32'(bus_s.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_onehot", 32'(bus.out_onehot), 32'(1) << q[0]);
`ifdef DECODE_THERMO_EN
            chk("out_mask", 32'(bus.out_mask), (32'(1) << (q[0] + 1)) - 1);
`endif
        end
        chk("xfer_count", 32'(bus.xfer_count), cnt);
        chk("xfer_count_s", 32'(bus_s.xfer_count), (cnt > 15) ? 15 : cnt);
    endtask

    task automatic cycle(input bit v, input bit [2:0] c, input bit r);
        bit acc, xf;
        drive(v, c, r);
        check_model();
        @(posedge clk);
        acc = v && m_rdy;
        xf  = (q.size() > 0) && r;
        if (xf) begin
            void'(q.pop_front());
            cnt++;
        end
        if (acc) q.push_back(int'(c));
        m_rdy = (q.size() < 2);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_onehot", 32'(bus.out_onehot), 0);
        chk("rst_xfer_count", 32'(bus.xfer_count), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
`ifdef DECODE_THERMO_EN
        chk("rst_out_mask", 32'(bus.out_mask), 0);
`endif
        q.delete();
        cnt   = 0;
        m_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // in_ready is still low before the first edge after release, then rises
        cycle(1'b0, 3'd0, 1'b0);
        chk("rel_in_ready", 32'(bus.in_ready), 1);
    endtask

    function automatic vec_t mk(bit v, bit [2:0] c, bit r, bit er, bit ev, bit [7:0] eoh, int ec);
        vec_t x;
        x.vld = v; x.code = c; x.ordy = r;
        x.exp_rdy = er; x.exp_vld = ev; x.exp_oh = eoh; x.exp_cnt = ec;
        return x;
    endfunction

    initial begin
        // sweep 0..7 with out_ready high
        tbl.push_back(mk(1, 0, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 8'h01, 0));
        tbl.push_back(mk(1, 2, 1, 1, 1, 8'h02, 1));
        tbl.push_back(mk(1, 3, 1, 1, 1, 8'h04, 2));
        tbl.push_back(mk(1, 4, 1, 1, 1, 8'h08, 3));
        tbl.push_back(mk(1, 5, 1, 1, 1, 8'h10, 4));
        tbl.push_back(mk(1, 6, 1, 1, 1, 8'h20, 5));
        tbl.push_back(mk(1, 7, 1, 1, 1, 8'h40, 6));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h80, 7));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8));
        // backpressure: 5 then 2 held, then drained in order
        tbl.push_back(mk(1, 5, 0, 1, 0, 8'h00, 8));
        tbl.push_back(mk(1, 2, 0, 1, 1, 8'h20, 8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h20, 8));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h20, 8));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h04, 9));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 10));
        // accept 6 and transfer in the same cycle while in ONE
        tbl.push_back(mk(1, 1, 0, 1, 0, 8'h00, 10));
        tbl.push_back(mk(1, 6, 1, 1, 1, 8'h02, 10));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h40, 11));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h40, 11));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 12));
        // fill both entries before the mid-stream reset
        tbl.push_back(mk(1, 3, 0, 1, 0, 8'h00, 12));
        tbl.push_back(mk(1, 4, 0, 1, 1, 8'h08, 12));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h08, 12));

        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0);
        @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld)
                chk($sformatf("tbl%0d_out_onehot", i), 32'(bus.out_onehot), 32'(tbl[i].exp_oh));
            chk($sformatf("tbl%0d_xfer_count", i), 32'(bus.xfer_count), tbl[i].exp_cnt);
            cycle(tbl[i].vld, tbl[i].code, tbl[i].ordy);
        end

        // abort with both entries occupied
        do_reset();

        // saturation: 20 transfers on the 4-bit counter instance
        for (int i = 0; i < 20; i++) cycle(1'b1, 3'(i), 1'b1);
        cycle(1'b0, 3'd0, 1'b1);
        cycle(1'b0, 3'd0, 1'b1);
        chk("sat_count_s", 32'(bus_s.xfer_count), 15);
        chk("sat_count", 32'(bus.xfer_count), 20);

`ifdef DECODE_THERMO_EN
        cycle(1'b1, 3'd3, 1'b1);
        chk("mask_code3", 32'(bus.out_mask), 32'h0F);
        cycle(1'b1, 3'd7, 1'b1);
        chk("mask_code7", 32'(bus.out_mask), 32'hFF);
        cycle(1'b1, 3'd0, 1'b1);
        chk("mask_code0", 32'(bus.out_mask), 32'h01);
        cycle(1'b0, 3'd0, 1'b1);
`endif

        // random traffic with random backpressure and one abort midway
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
